// File: rtl/comparator_3bit_bist_if.sv
// Operand/response bus between the BIST engine (master) and the 3-bit
// comparator under test (slave).
interface comparator_3bit_bist_if;
    logic [2:0] dut_a;
    logic [2:0] dut_b;
    logic       dut_greater;
    logic       dut_equal;
    logic       dut_less;

    modport master (
        output dut_a,
        output dut_b,
        input  dut_greater,
        input  dut_equal,
        input  dut_less
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        output dut_greater,
        output dut_equal,
        output dut_less
    );
endinterface

// File: rtl/comparator_3bit_bist.sv
// Built-in self test for a 3-bit magnitude comparator. A 16-bit Fibonacci
// LFSR supplies one operand pair per RUN cycle. The expected one-hot result
// travels down a valid-tagged delay line so it meets the comparator's answer
// DUT_LATENCY+1 edges after issue. Mismatches are counted with saturation,
// and the first failing pair is captured.
module comparator_3bit_bist #(
    parameter logic [31:0] NUM_VECTORS = 32'd10000,
    parameter int unsigned DUT_LATENCY = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    comparator_3bit_bist_if.master        cmp,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [15:0]                   err_count,
    output logic                          first_fail_valid,
    output logic [2:0]                    first_fail_a,
    output logic [2:0]                    first_fail_b
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] exp_oh;
    } chk_t;

    localparam int         DEPTH      = int'(DUT_LATENCY) + 1;
    // A zero seed would lock the LFSR, so it is replaced by 1 at run start.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [2:0] DRAIN_LAST = (DUT_LATENCY > 0) ? 3'(DUT_LATENCY - 1) : 3'd0;

    // Taps 16,14,13,11; shift left, feedback enters bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Unsigned compare, result as {greater, equal, less}.
    function automatic logic [2:0] expect_onehot(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        if (a > b) begin
            r = 3'b100;
        end else if (a == b) begin
            r = 3'b010;
        end else begin
            r = 3'b001;
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [2:0]        drain_q, drain_d;
    logic [2:0]        a_q, a_d, b_q, b_d;
    logic [15:0]       err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [2:0]        ffa_q, ffa_d, ffb_q, ffb_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    chk_t [DEPTH-1:0]  pipe_q, pipe_d;
    chk_t              chk_s;
    logic [2:0]        resp_s;
    logic              fail_s;
    logic              issue_s;

    // Next-state, stimulus issue, result checking and output decode.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;
        issue_s = 1'b0;
        pipe_d  = '0;

        chk_s  = pipe_q[DEPTH-1];
        resp_s = {cmp.dut_greater, cmp.dut_equal, cmp.dut_less};
        fail_s = chk_s.valid && (resp_s != chk_s.exp_oh);

        if (fail_s) begin
            err_d = (err_q == 16'hFFFF) ? err_q : (err_q + 16'd1);
            if (!ffv_q) begin
                ffv_d = 1'b1;
                ffa_d = chk_s.a;
                ffb_d = chk_s.b;
            end else begin
                ffv_d = ffv_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                // The accepting edge also issues vector 0 straight from the seed.
                if (start) begin
                    state_d = S_RUN;
                    a_d     = SEED_EFF[2:0];
                    b_d     = SEED_EFF[5:3];
                    lfsr_d  = lfsr_step(SEED_EFF);
                    issue_s = 1'b1;
                    cnt_d   = 32'd1;
                    drain_d = 3'd0;
                    err_d   = 16'd0;
                    ffv_d   = 1'b0;
                    ffa_d   = 3'd0;
                    ffb_d   = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (cnt_q == NUM_VECTORS) begin
                    state_d = (DUT_LATENCY == 0) ? S_DONE : S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    a_d     = lfsr_q[2:0];
                    b_d     = lfsr_q[5:3];
                    lfsr_d  = lfsr_step(lfsr_q);
                    issue_s = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pipe_d[0] = '{valid: issue_s, a: a_d, b: b_d, exp_oh: expect_onehot(a_d, b_d)};
        for (int k = 1; k < DEPTH; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 16'd0);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, delay line and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= SEED;
            cnt_q   <= 32'd0;
            drain_q <= 3'd0;
            a_q     <= 3'd0;
            b_q     <= 3'd0;
            err_q   <= 16'd0;
            ffv_q   <= 1'b0;
            ffa_q   <= 3'd0;
            ffb_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            pipe_q  <= pipe_d;
        end
    end

    assign cmp.dut_a        = a_q;
    assign cmp.dut_b        = b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_a     = ffa_q;
    assign first_fail_b     = ffb_q;

endmodule

// File: tb/tb_comparator_3bit_bist.sv
// Directed bench for comparator_3bit_bist: golden, stuck-equal, multi-hot,
// zero-latency, saturation, start-handling and mid-run reset scenarios.
module tb_comparator_3bit_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start0, start_s;
    logic [1:0] mode;            // 0 correct, 1 equal stuck 0, 2 all-hot
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    // First 16 {A,B} pairs from seed 16'hACE1, worked by hand (octal: A digit, B digit).
    localparam logic [5:0] VEC_TBL [16] = '{
        6'o14, 6'o30, 6'o70, 6'o71, 6'o63, 6'o47, 6'o17, 6'o26,
        6'o44, 6'o01, 6'o12, 6'o24, 6'o50, 6'o21, 6'o52, 6'o25
    };

    comparator_3bit_bist_if if1 ();
    comparator_3bit_bist_if if0 ();
    comparator_3bit_bist_if ifs ();

    logic        busy1, done1, pass1, ffv1, busy0, done0, pass0, ffv0, busy_s, done_s, pass_s, ffv_s;
    logic [15:0] err1, err0, err_s;
    logic [2:0]  ffa1, ffb1, ffa0, ffb0, ffa_s, ffb_s;

    comparator_3bit_bist #(.NUM_VECTORS(32'd16), .DUT_LATENCY(1), .SEED(16'hACE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cmp(if1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_a(ffa1), .first_fail_b(ffb1));

    comparator_3bit_bist #(.NUM_VECTORS(32'd16), .DUT_LATENCY(0), .SEED(16'hACE1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cmp(if0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0), .first_fail_a(ffa0), .first_fail_b(ffb0));

    comparator_3bit_bist #(.NUM_VECTORS(32'd70000), .DUT_LATENCY(1), .SEED(16'hACE1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .cmp(ifs),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_fail_valid(ffv_s), .first_fail_a(ffa_s), .first_fail_b(ffb_s));

    function automatic logic [2:0] ref_cmp(input logic [2:0] a, input logic [2:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // Registered comparator model for the latency-1 instance, with fault modes.
    logic [2:0] ref1_q;
    always_ff @(posedge clk) ref1_q <= ref_cmp(if1.dut_a, if1.dut_b);
    logic [2:0] resp1;
    assign resp1 = (mode == 2'd0) ? ref1_q : (mode == 2'd1) ? (ref1_q & 3'b101) : 3'b111;
    assign {if1.dut_greater, if1.dut_equal, if1.dut_less} = resp1;

    // Combinational correct model for the zero-latency instance.
    assign {if0.dut_greater, if0.dut_equal, if0.dut_less} = ref_cmp(if0.dut_a, if0.dut_b);

    // Always-wrong (all-zero) responder for the saturation instance.
    assign {ifs.dut_greater, ifs.dut_equal, ifs.dut_less} = 3'b000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start1();
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input string tag, input int budget);
        int n = 0;
        while (done1 !== 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 32'(done1), 32'd1);
    endtask

    // Correct-model run on the latency-1 instance; start stays high through E(hold).
    task automatic run_golden1(input string tag, input int hold);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start1 = 1'b0;
        check_eq($sformatf("%s_vec0", tag), 32'({if1.dut_a, if1.dut_b}), 32'(VEC_TBL[0]));
        for (int i = 1; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == hold) start1 = 1'b0;
            check_eq($sformatf("%s_vec%0d", tag, i), 32'({if1.dut_a, if1.dut_b}), 32'(VEC_TBL[i]));
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_done_e16"}, 32'(done1), 32'd0);
        check_eq({tag, "_busy_e16"}, 32'(busy1), 32'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_e17"}, 32'(done1), 32'd1);
        check_eq({tag, "_busy_e17"}, 32'(busy1), 32'd0);
        check_eq({tag, "_err"}, 32'(err1), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass1), 32'd1);
        check_eq({tag, "_ffv"}, 32'(ffv1), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start1  = 1'b0;
        start0  = 1'b0;
        start_s = 1'b0;
        mode    = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dut_ab", 32'({if1.dut_a, if1.dut_b}), 32'd0);
        check_eq("rst_flags", 32'({busy1, done1, pass1, ffv1}), 32'd0);
        check_eq("rst_err", 32'(err1), 32'd0);
        check_eq("rst_ff_ab", 32'({ffa1, ffb1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("idle_busy", 32'(busy1), 32'd0);
        check_eq("idle_done", 32'(done1), 32'd0);

        // Golden run, then results must hold in DONE.
        run_golden1("gold", 0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_done", 32'(done1), 32'd1);
        check_eq("hold_pass", 32'(pass1), 32'd1);

        // Equal output stuck at 0: only vector 8 (4,4) is A==B.
        mode = 2'd1;
        pulse_start1();
        wait_done1("stuck_done", 40);
        check_eq("stuck_err", 32'(err1), 32'd1);
        check_eq("stuck_ffv", 32'(ffv1), 32'd1);
        check_eq("stuck_ff_ab", 32'({ffa1, ffb1}), 32'(6'o44));
        check_eq("stuck_pass", 32'(pass1), 32'd0);

        // Restart from DONE clears counters and replays the same sequence.
        pulse_start1();
        check_eq("rst2_err", 32'(err1), 32'd0);
        check_eq("rst2_ffv", 32'(ffv1), 32'd0);
        check_eq("rst2_done", 32'(done1), 32'd0);
        check_eq("rst2_vec0", 32'({if1.dut_a, if1.dut_b}), 32'(VEC_TBL[0]));
        @(posedge clk);
        #1;
        check_eq("rst2_vec1", 32'({if1.dut_a, if1.dut_b}), 32'(VEC_TBL[1]));
        wait_done1("rst2_done_end", 40);
        check_eq("rst2_err_end", 32'(err1), 32'd1);

        // Multi-hot responses: every one of the 16 checks fails.
        mode = 2'd2;
        pulse_start1();
        wait_done1("mh_done", 40);
        check_eq("mh_err", 32'(err1), 32'd16);
        check_eq("mh_ff_ab", 32'({ffa1, ffb1}), 32'(VEC_TBL[0]));
        check_eq("mh_pass", 32'(pass1), 32'd0);

        // start held high through most of RUN must not restart anything.
        mode = 2'd0;
        run_golden1("held", 10);

        // Zero-latency instance with combinational model: done at E(16).
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("lat0_done_e15", 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat0_done_e16", 32'(done0), 32'd1);
        check_eq("lat0_pass", 32'(pass0), 32'd1);
        check_eq("lat0_err", 32'(err0), 32'd0);
        check_eq("lat0_ff", 32'({ffv0, ffa0, ffb0}), 32'd0);
        check_eq("lat0_busy", 32'(busy0), 32'd0);

        // Saturation: 70000 wrong answers stop at 16'hFFFF.
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        begin
            int n = 0;
            while (done_s !== 1'b1 && n < 70100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_eq("sat_done", 32'(done_s), 32'd1);
        check_eq("sat_err", 32'(err_s), 32'hFFFF);
        check_eq("sat_pass", 32'(pass_s), 32'd0);
        check_eq("sat_busy", 32'(busy_s), 32'd0);
        check_eq("sat_ff", 32'({ffv_s, ffa_s, ffb_s}), 32'({1'b1, VEC_TBL[0]}));

        // Reset at vector 5 of a failing run: outputs clear at once, no residue.
        mode = 2'd2;
        pulse_start1();
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_vec5", 32'({if1.dut_a, if1.dut_b}), 32'(VEC_TBL[5]));
        check_eq("mid_err_pre", 32'(err1), 32'd4);
        rst_n = 1'b0;
        #1;
        check_eq("mid_async_ab", 32'({if1.dut_a, if1.dut_b}), 32'd0);
        check_eq("mid_async_flags", 32'({busy1, done1, pass1, ffv1}), 32'd0);
        check_eq("mid_async_err", 32'(err1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("post_err", 32'(err1), 32'd0);
        check_eq("post_flags", 32'({busy1, done1, pass1, ffv1}), 32'd0);
        check_eq("post_ab", 32'({if1.dut_a, if1.dut_b}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
